// File: rtl/counter_run_ctrl.sv
// Run/stop and clear control for the display counter: synchronizes and debounces
// two raw push-buttons, toggles a run state and emits a one-cycle clear pulse.
module counter_run_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_WIDTH       = 20
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_run,
    input  logic btn_clr,
    output logic enable,
    output logic clear,
    output logic debounce_busy
);

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 run_s1, run_s2, run_stable, run_stable_d;
    logic                 clr_s1, clr_s2, clr_stable, clr_stable_d;
    logic [CNT_WIDTH-1:0] run_cnt, clr_cnt;
    logic [CNT_WIDTH-1:0] run_cnt_next, clr_cnt_next;
    logic                 run_stable_next, clr_stable_next;
    logic                 run_press, clr_press;
    state_t               state, state_next;
    logic                 clear_next;

    // A level is accepted only after it has disagreed with the stable value for
    // DEBOUNCE_CYCLES consecutive edges; any agreement restarts the count.
    always_comb begin
        run_cnt_next    = run_cnt + 1'b1;
        run_stable_next = run_stable;
        if (run_s2 == run_stable) begin
            run_cnt_next = '0;
        end else if (run_cnt == CNT_LAST) begin
            run_cnt_next    = '0;
            run_stable_next = run_s2;
        end

        clr_cnt_next    = clr_cnt + 1'b1;
        clr_stable_next = clr_stable;
        if (clr_s2 == clr_stable) begin
            clr_cnt_next = '0;
        end else if (clr_cnt == CNT_LAST) begin
            clr_cnt_next    = '0;
            clr_stable_next = clr_s2;
        end
    end

    assign run_press = run_stable & ~run_stable_d;
    assign clr_press = clr_stable & ~clr_stable_d;

    always_comb begin
        state_next = state;
        clear_next = 1'b0;
        if (clr_press) begin
            state_next = STOPPED;
            clear_next = 1'b1;
        end else if (run_press) begin
            state_next = (state == RUNNING) ? STOPPED : RUNNING;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            run_s1        <= 1'b0;
            run_s2        <= 1'b0;
            run_stable    <= 1'b0;
            run_stable_d  <= 1'b0;
            run_cnt       <= '0;
            clr_s1        <= 1'b0;
            clr_s2        <= 1'b0;
            clr_stable    <= 1'b0;
            clr_stable_d  <= 1'b0;
            clr_cnt       <= '0;
            state         <= STOPPED;
            enable        <= 1'b0;
            clear         <= 1'b0;
            debounce_busy <= 1'b0;
        end else begin
            run_s1        <= btn_run;
            run_s2        <= run_s1;
            run_stable    <= run_stable_next;
            run_stable_d  <= run_stable;
            run_cnt       <= run_cnt_next;
            clr_s1        <= btn_clr;
            clr_s2        <= clr_s1;
            clr_stable    <= clr_stable_next;
            clr_stable_d  <= clr_stable;
            clr_cnt       <= clr_cnt_next;
            state         <= state_next;
            enable        <= (state_next == RUNNING);
            clear         <= clear_next;
            debounce_busy <= (run_cnt_next != '0) | (clr_cnt_next != '0);
        end
    end

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Bench for counter_run_ctrl with DEBOUNCE_CYCLES=4: directed button scenarios plus
// random button activity, checked against a history-based behavioural model.
module tb_counter_run_ctrl;

    localparam int D  = 4;
    localparam int CW = 3;

    logic clock = 1'b0;
    logic reset;
    logic btn_run;
    logic btn_clr;
    logic enable;
    logic clear;
    logic debounce_busy;

    int checks   = 0;
    int failures = 0;

    counter_run_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .CNT_WIDTH      (CW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .btn_run      (btn_run),
        .btn_clr      (btn_clr),
        .enable       (enable),
        .clear        (clear),
        .debounce_busy(debounce_busy)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Index 0 = run button, 1 = clear button. The raw level reaches the debouncer
    // two edges late; a level is accepted once the last D observed samples all
    // disagree with the accepted level.
    bit        raw_dly1 [2];
    bit        raw_dly2 [2];
    bit        win      [2][D];
    int        win_len  [2];
    bit        m_stable [2];
    bit        m_press  [2];
    bit        m_running;
    bit        m_clear;
    logic [2:0] exp_q[$];

    always @(posedge clock) begin
        bit raw [2];
        bit busy;
        raw[0] = btn_run;
        raw[1] = btn_clr;
        busy   = 1'b0;
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                raw_dly1[b] = 1'b0;
                raw_dly2[b] = 1'b0;
                win_len[b]  = 0;
                m_stable[b] = 1'b0;
                m_press[b]  = 1'b0;
            end
            m_running = 1'b0;
            m_clear   = 1'b0;
        end else begin
            if (m_press[1]) begin
                m_running = 1'b0;
                m_clear   = 1'b1;
            end else if (m_press[0]) begin
                m_running = !m_running;
                m_clear   = 1'b0;
            end else begin
                m_clear = 1'b0;
            end
            for (int b = 0; b < 2; b++) begin
                bit seen;
                int streak;
                seen        = raw_dly2[b];
                raw_dly2[b] = raw_dly1[b];
                raw_dly1[b] = raw[b];
                for (int i = D - 1; i > 0; i--) win[b][i] = win[b][i-1];
                win[b][0] = seen;
                if (win_len[b] < D) win_len[b]++;
                streak = 0;
                for (int i = 0; i < win_len[b]; i++) begin
                    if (win[b][i] == m_stable[b]) break;
                    streak++;
                end
                m_press[b] = 1'b0;
                if (streak >= D) begin
                    m_press[b]  = !m_stable[b];
                    m_stable[b] = !m_stable[b];
                    streak      = 0;
                end
                if (streak != 0) busy = 1'b1;
            end
        end
        exp_q.push_back({busy, m_clear, m_running});
    end

    // ---------------- scoreboard ----------------
    logic prev_clear = 1'b0;
    always @(negedge clock) begin
        logic [2:0] exp;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check("enable", enable, exp[0]);
            check("clear", clear, exp[1]);
            check("debounce_busy", debounce_busy, exp[2]);
            check("clear_width", clear & prev_clear, 1'b0);
        end
        prev_clear = clear;
    end

    // ---------------- driver tasks ----------------
    task automatic hold(input bit r, input bit c, input int n);
        btn_run = r;
        btn_clr = c;
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset   = 1'b1;
        btn_run = 1'b0;
        btn_clr = 1'b0;
        // Reset held with buttons toggling: outputs must stay low.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("reset_enable", enable, 1'b0);
            check("reset_clear", clear, 1'b0);
            check("reset_busy", debounce_busy, 1'b0);
            btn_run = $urandom_range(0, 1);
            btn_clr = $urandom_range(0, 1);
        end
        btn_run = 1'b0;
        btn_clr = 1'b0;
        reset   = 1'b0;
        @(negedge clock);
        check("post_reset_enable", enable, 1'b0);
        check("post_reset_busy", debounce_busy, 1'b0);
        hold(0, 0, 4);

        // Clean run press: enable rises exactly 6 edges after first sample.
        btn_run = 1'b1;
        repeat (6) @(negedge clock);
        check("run_latency_early", enable, 1'b0);
        @(negedge clock);
        check("run_latency", enable, 1'b1);
        hold(1, 0, 13);
        check("run_held", enable, 1'b1);
        hold(0, 0, 8);
        btn_run = 1'b1;
        repeat (6) @(negedge clock);
        check("stop_latency_early", enable, 1'b1);
        @(negedge clock);
        check("stop_latency", enable, 1'b0);
        hold(1, 0, 5);
        hold(0, 0, 8);

        // Glitch rejection: 3-cycle pulses never accepted.
        for (int i = 0; i < 5; i++) begin
            hold(1, 0, 3);
            hold(0, 0, 1);
        end
        hold(0, 0, 6);
        check("glitch_enable", enable, 1'b0);

        // Clear while running.
        hold(1, 0, 10);
        hold(0, 0, 8);
        check("running_before_clear", enable, 1'b1);
        btn_clr = 1'b1;
        repeat (6) @(negedge clock);
        check("clr_latency_early", clear, 1'b0);
        @(negedge clock);
        check("clr_pulse", clear, 1'b1);
        check("clr_stops", enable, 1'b0);
        @(negedge clock);
        check("clr_pulse_end", clear, 1'b0);
        hold(0, 1, 10);
        hold(0, 0, 8);

        // Simultaneous press: clear wins.
        btn_run = 1'b1;
        btn_clr = 1'b1;
        repeat (7) @(negedge clock);
        check("simul_clear", clear, 1'b1);
        check("simul_enable", enable, 1'b0);
        @(negedge clock);
        check("simul_clear_end", clear, 1'b0);
        hold(0, 0, 8);

        // Reset mid-debounce.
        hold(1, 0, 3);
        pulse_reset();
        hold(1, 0, 1);
        hold(0, 0, 15);
        check("rst_mid_enable", enable, 1'b0);
        check("rst_mid_clear", clear, 1'b0);

        // Random button activity with occasional resets.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 29) == 0) pulse_reset();
            hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 10));
        end
        hold(0, 0, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_run_ctrl.md
Name: counter_run_ctrl

Overview:
Upstream control stage for the 4-bit display counter. It turns two raw, bouncing push-buttons (run/stop and clear) into clean control signals.
- Run/stop button: toggles a registered run state, which drives the counter's enable input.
- Clear button: produces a single-cycle clear pulse, which the top level ORs into the counter's synchronous reset.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive cycles a synchronized button level must hold before it is accepted (20 ms at 50 MHz); legal range >= 2
CNT_WIDTH, 20, width of each debounce counter; 2**CNT_WIDTH must exceed DEBOUNCE_CYCLES

Ports:
clock  input  1  design clock
reset  input  1  synchronous, active-high reset
btn_run  input  1  raw asynchronous run/stop button, active high
btn_clr  input  1  raw asynchronous clear button, active high
enable  output  1  registered run state; 1 = counter counts
clear  output  1  registered single-cycle clear pulse
debounce_busy  output  1  registered; 1 while either debounce counter is non-zero

Behaviour:
- One clock; reset is synchronous and active-high. All state updates on posedge clock.
- Reset values (reset sampled high at an edge):
  - enable=0, clear=0, debounce_busy=0
  - all synchronizer flops 0; both stable levels and their delayed copies 0
  - both debounce counters 0; FSM state STOPPED
- Synchronizer: two flops per button (s1, s2); no logic between them.
- Debounce, per button, evaluated each edge:
  - s2 == stable: cnt <= 0.
  - s2 != stable and cnt == DEBOUNCE_CYCLES-1: stable <= s2, cnt <= 0.
  - otherwise: cnt <= cnt+1.
- Glitch rejection: an s2 excursion shorter than DEBOUNCE_CYCLES cycles never changes stable.
- Edge detect: stable_d <= stable every edge. press = stable & ~stable_d (combinational, one cycle wide). Release edges are ignored.
- FSM, two states, STOPPED and RUNNING:
  - clr_press: state <= STOPPED, clear <= 1. Clear has priority over a simultaneous run_press.
  - run_press only: STOPPED -> RUNNING, RUNNING -> STOPPED; clear <= 0.
  - neither: hold state; clear <= 0.
  - enable is the registered decode (state == RUNNING); it changes on the same edge as state.
- Latency: raw button high sampled first at edge k and held:
  - stable = 1 after edge k+DEBOUNCE_CYCLES+1
  - enable/clear update after edge k+DEBOUNCE_CYCLES+2
  - with DEBOUNCE_CYCLES=4: update after edge k+6
- Holding a button: produces exactly one press. A new press requires release to be debounced (DEBOUNCE_CYCLES stable low) first.
- clear: high exactly one cycle per accepted clear press, never longer.
- Reset mid-operation:
  - all counters and stable levels return to 0 on that edge.
  - a button still held when reset deasserts is re-debounced from zero and is accepted as a new press.
- debounce_busy <= (next run cnt != 0) | (next clr cnt != 0), registered alongside the counters.
- No counter wrap is possible: cnt never exceeds DEBOUNCE_CYCLES-1.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, CNT_WIDTH=3.
1. Reset:
   - Stimulus: reset high 3 edges, buttons toggling.
   - Required: enable=0, clear=0, debounce_busy=0 throughout and on the first edge after reset drops.
2. Clean run press:
   - Stimulus: btn_run high from edge 10, held 20 cycles.
   - Required: enable rises after edge 16 and stays 1; clear stays 0. Release, debounce, press again → enable falls after the second press's k+6.
3. Glitch rejection:
   - Stimulus: btn_run high for 3 cycles, then low; repeat 5 times with 1-cycle gaps.
   - Required: enable stays 0; debounce_busy pulses high.
4. Clear while running:
   - Stimulus: enable=1; btn_clr high from edge 40, held.
   - Required: clear=1 only in the cycle after edge 46; enable=0 from edge 46; no second clear while held.
5. Simultaneous press:
   - Stimulus: from STOPPED, btn_run and btn_clr rise at the same edge 60.
   - Required: after edge 66, clear=1 for one cycle and enable=0.
6. Reset mid-debounce:
   - Stimulus: btn_run high from edge 80; reset high at edge 83 for 1 cycle; btn_run released at edge 85.
   - Required: enable stays 0 and clear stays 0 through edge 100.
